pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data registers, each stage with its own valid bit.
- Upstream and downstream interfaces are valid/ready handshakes.
- Bubbles collapse: any stage accepts new data when it is empty or is itself advancing.
- Adds synchronous flush and an occupancy count; used as the standard retiming/decoupling stage between datapath blocks.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1; DEPTH=0 is illegal, elaboration-time error)
RESET_VALUE, 0, value loaded into every data register on reset and flush (WIDTH bits)
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all stages
in_valid  input  1  upstream data valid
in_ready  output  1  pipeline can accept in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  stage DEPTH-1 holds valid data
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  data of stage DEPTH-1
count  output  CNT_W  number of valid stages, 0..DEPTH

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0, all data registers RESET_VALUE, count 0.
  - Outputs after reset: out_valid=0, out_data=RESET_VALUE, in_ready=1.
- Stage i holds vld[i] and dat[i]. Stage 0 is fed by the input; stage DEPTH-1 drives the outputs.
- Advance condition, combinational chain from the output back to the input:
  - adv[DEPTH-1] = !vld[DEPTH-1] | out_ready
  - adv[i] = !vld[i] | adv[i+1]
  - in_ready = adv[0] & !flush
- On each rising edge where adv[i]=1 and flush=0:
  - Stage 0 loads vld[0] <= in_valid and dat[0] <= in_data.
  - Stage i>0 loads vld[i] <= vld[i-1] and dat[i] <= dat[i-1].
- When adv[i]=0, stage i holds its contents.
- Data registers update only when the incoming valid is 1; otherwise they hold. This keeps out_data stable while a stage is empty.
- Latency: on an empty pipe, a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles of latency.
- Throughput is 1 word/cycle while out_ready=1.
- Stable-output rule: while out_valid=1 and out_ready=0, out_valid and out_data hold until the transfer.
- Full: all vld=1 and out_ready=0 -> in_ready=0. Simultaneous full + out_ready=1 -> in_ready=1 and the pipe shifts, giving pass-through at full rate.
- Empty: count=0, out_valid=0, in_ready=1 regardless of out_ready.
- Flush (synchronous, priority over all handshakes):
  - During a flush cycle: in_ready=0, and no input or output transfer counts even if out_ready=1.
  - At the next edge: all vld <= 0, data <= RESET_VALUE, count <= 0.
- count is registered:
  - +1 on in_valid & in_ready only; -1 on out_valid & out_ready only; holds on both or neither; 0 on flush.
  - It must always equal popcount(vld).
- Reset asserted mid-stream: contents are discarded immediately and asynchronously. Release is synchronous to the next clk edge; first acceptance is possible on the edge after release.
- DEPTH=1: in_ready = (!vld[0] | out_ready) & !flush. count is 1 bit.

Decomposition:
- Package pipe_pkg:
  - CNT_W derivation function (clog2 helper).
  - Localparam for maximum supported DEPTH (64), checked at elaboration.
- Natural sub-module pipe_stage: one valid+data register with load/hold/clear inputs (load, clr, d_valid, d_data). It is instantiated DEPTH times in a generate loop; the top module owns the adv chain and the counter.

Test Plan (WIDTH=8, DEPTH=3, RESET_VALUE=0):
1. Reset: hold rst=0 across 2 edges, release -> out_valid=0, out_data=8'h00, count=0, in_ready=1.
2. Latency/throughput: out_ready=1, send 8'hA1, 8'hA2, 8'hA3 on consecutive cycles -> out_data shows A1, A2, A3 on 3 consecutive cycles, the first 3 cycles after A1 is accepted; count peaks at 3 and returns to 0.
3. Backpressure/full: out_ready=0, offer 4 words 8'h10..8'h13 -> first 3 accepted, in_ready=0, count=3, out_data=8'h10 held stable. Raise out_ready -> 8'h10..8'h13 emerge in order with no loss or duplication.
4. Bubble collapse: send 8'h55, idle 2 cycles, send 8'h66 with out_ready=0 -> both stack at stages 2 and 1, count=2. Release out_ready -> 55 then 66 on back-to-back cycles.
5. Flush: fill with 8'hC0..8'hC2, pulse flush with in_valid=1 and out_ready=1 -> during flush in_ready=0 and no transfer; next cycle count=0, out_valid=0, out_data=8'h00. The word 8'hC3 offered during flush is not accepted.
6. Async reset mid-stream: with count=2, drop rst between edges -> out_valid=0 and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
//   MAX_DEPTH : largest supported number of stages
//   clog2     : ceiling log2, usable in constant expressions
//   cnt_width : width of an occupancy counter covering 0..depth
package pipe_pkg;

   localparam int unsigned MAX_DEPTH = 64;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data register.
// Ports:
//   clk, rst        : clock and asynchronous active-low reset
//   load            : take d_valid (and d_data when d_valid=1) this edge
//   clr             : synchronous clear, wins over load
//   d_valid, d_data : incoming stage contents
//   q_valid, q_data : registered stage contents
module pipe_stage #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clr,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_valid <= 1'b0;
         q_data  <= RESET_VALUE;
      end else if (clr) begin
         q_valid <= 1'b0;
         q_data  <= RESET_VALUE;
      end else if (load) begin
         q_valid <= d_valid;
         // Bubbles leave the data untouched so out_data stays stable when empty.
         if (d_valid) q_data <= d_data;
      end
   end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline of DEPTH stages with valid/ready on both sides,
// bubble collapsing, synchronous flush and a registered occupancy count.
// Ports:
//   clk, rst                       : clock and asynchronous active-low reset
//   flush                          : synchronous clear of every stage
//   in_valid, in_ready, in_data    : upstream handshake
//   out_valid, out_ready, out_data : downstream handshake (last stage)
//   count                          : number of valid stages, 0..DEPTH
module pipe_reg_chain
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      DEPTH       = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int unsigned     CNT_W       = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
);

   if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("pipe_reg_chain: DEPTH must be within 1..64");
   end

   logic [DEPTH-1:0]            vld;
   logic [DEPTH-1:0][WIDTH-1:0] dat;
   logic [DEPTH-1:0]            adv;
   logic [DEPTH-1:0]            load;

   // A stage advances when it or any stage after it is empty, or the output
   // drains. This is the unrolled form of adv[i] = !vld[i] | adv[i+1].
   always_comb begin
      logic tail_full;
      tail_full = 1'b1;
      adv       = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         tail_full = tail_full & vld[i];
         adv[i]    = ~tail_full | out_ready;
      end
   end

   assign load      = flush ? '0 : adv;
   assign in_ready  = adv[0] & ~flush;
   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             s_valid;
      logic [WIDTH-1:0] s_data;

      if (i == 0) begin : g_head
         assign s_valid = in_valid;
         assign s_data  = in_data;
      end else begin : g_body
         assign s_valid = vld[i-1];
         assign s_data  = dat[i-1];
      end

      pipe_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .load    (load[i]),
         .clr     (flush),
         .d_valid (s_valid),
         .d_data  (s_data),
         .q_valid (vld[i]),
         .q_data  (dat[i])
      );
   end

   logic             in_fire;
   logic             out_fire;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready & ~flush;

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         unique case ({in_fire, out_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;

   localparam int unsigned W = 8;
   localparam int          D = 3;

   logic         clk       = 1'b0;
   logic         rst       = 1'b0;
   logic         flush     = 1'b0;
   logic         in_valid  = 1'b0;
   logic [W-1:0] in_data   = '0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   count;

   always #5 clk = ~clk;

   pipe_reg_chain #(
      .WIDTH       (W),
      .DEPTH       (D),
      .RESET_VALUE (8'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   // Reference model: words in arrival order, each with the stage it sits in.
   logic [W-1:0] mq_data[$];
   int           mq_pos[$];
   logic [W-1:0] m_last = '0;   // last word that reached the output stage

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic m_out_valid();
      return (mq_data.size() > 0) && (mq_pos[0] == D - 1);
   endfunction

   // Acceptance is possible whenever any slot is free or the output drains.
   function automatic logic m_in_ready(input logic fl, input logic ordy);
      return !fl && ((mq_data.size() < D) || ordy);
   endfunction

   task automatic model_clear();
      mq_data.delete();
      mq_pos.delete();
      m_last = '0;
   endtask

   // Called at posedge+1: apply inputs, check outputs, clock once, update model.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic fl);
      logic exp_ov, exp_ir, in_fire, out_fire;
      int   lim;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      exp_ov = m_out_valid();
      exp_ir = m_in_ready(fl, ordy);
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("out_data", 32'(out_data), 32'(m_last));
      check("count", 32'(count), 32'(mq_data.size()));
      in_fire  = v && exp_ir;
      out_fire = exp_ov && ordy && !fl;
      @(posedge clk);
      #1;
      if (fl) begin
         model_clear();
      end else begin
         if (out_fire) begin
            void'(mq_data.pop_front());
            void'(mq_pos.pop_front());
         end
         // Each word moves one stage forward unless the word ahead blocks it.
         lim = D;
         foreach (mq_pos[k]) begin
            mq_pos[k] = (mq_pos[k] + 1 < lim - 1) ? mq_pos[k] + 1 : lim - 1;
            lim       = mq_pos[k];
         end
         if (in_fire) begin
            mq_data.push_back(d);
            mq_pos.push_back(0);
         end
         if (m_out_valid()) m_last = mq_data[0];
      end
   endtask

   initial begin
      int idx;
      logic ordy;

      // 1. reset held over two edges, released between edges
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h00);
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // 2. latency and throughput
      cycle(1'b1, 8'hA1, 1'b1, 1'b0);
      cycle(1'b1, 8'hA2, 1'b1, 1'b0);
      cycle(1'b1, 8'hA3, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // 3. backpressure until full, then drain
      idx = 0;
      for (int n = 0; n < 14; n++) begin
         ordy = (n >= 6);
         if (idx < 4 && m_in_ready(1'b0, ordy)) begin
            cycle(1'b1, 8'h10 + 8'(idx), ordy, 1'b0);
            idx++;
         end else begin
            cycle(idx < 4, 8'h10 + 8'(idx), ordy, 1'b0);
         end
      end
      check("bp_all_sent", 32'(idx), 32'd4);

      // 4. bubble collapse
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 8'h66, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // 5. flush of a full pipe with traffic offered on both sides
      cycle(1'b1, 8'hC0, 1'b0, 1'b0);
      cycle(1'b1, 8'hC1, 1'b0, 1'b0);
      cycle(1'b1, 8'hC2, 1'b0, 1'b0);
      cycle(1'b1, 8'hC3, 1'b1, 1'b1);
      #1;
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_out_data", 32'(out_data), 32'h00);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // 6. asynchronous reset mid-stream
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      cycle(1'b1, 8'h78, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      check("arst_out_data", 32'(out_data), 32'h00);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
               ($urandom % 25) == 0);
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
